// File: rtl/sensor_bus_pkg.sv
// sensor_bus_pkg: shared state type, defaults and SPI byte-handshake constants for the sensor bus
package sensor_bus_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_GRANT, ST_BUSY, ST_DONE, ST_GAP} state_t;
    localparam int NUM_REQ_DEF = 2;
    localparam int SPI_BYTE_W = 8;
    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] TIMEOUT_DEF = 24'hFFFFFF;
    localparam logic [11:0] SS_GAP_DEF = 12'hFFF;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: requester-side and SPI-master-side signals of the shared sensor bus
interface spi_bus_arbiter_if
    import sensor_bus_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
);
    localparam int IW = idx_w(NUM_REQ);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            begin_in;
    logic [SPI_BYTE_W*NUM_REQ-1:0] send_data_in;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            end_out;
    logic [SPI_BYTE_W-1:0]         recieved_data_out;
    logic                          begin_transmission;
    logic [SPI_BYTE_W-1:0]         send_data;
    logic                          end_transmission;
    logic [SPI_BYTE_W-1:0]         recieved_data;
    logic [NUM_REQ-1:0]            ss_n;
    logic                          timeout_err;
    logic [IW-1:0]                 err_id;
    // slave is the arbiter's view; master is the surrounding sensor FSMs and SPI master
    modport slave (
        input  req, begin_in, send_data_in, end_transmission, recieved_data,
        output gnt, end_out, recieved_data_out, begin_transmission, send_data, ss_n, timeout_err, err_id
    );
    modport master (
        output req, begin_in, send_data_in, end_transmission, recieved_data,
        input  gnt, end_out, recieved_data_out, begin_transmission, send_data, ss_n, timeout_err, err_id
    );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: round-robin priority encoder, first set request at or after ptr with wrap-around
module rr_picker
    import sensor_bus_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_index,
    output logic          o_any
);
    function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int k);
        return IW'((int'(p) + k) % N);
    endfunction

    // scan from the farthest offset down so the nearest hit to ptr wins
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = |i_req;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[rot(i_ptr, k)]) begin
                o_index  = rot(i_ptr, k);
                o_onehot = N'(1) << rot(i_ptr, k);
            end
        end
    end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one byte-level SPI master between sensor FSMs
module spi_bus_arbiter
    import sensor_bus_pkg::*;
#(
    parameter int               NUM_REQ = NUM_REQ_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = TIMEOUT_DEF,
    parameter logic [11:0]      SS_GAP  = SS_GAP_DEF
) (
    input logic              clk,
    input logic              rst,
    spi_bus_arbiter_if.slave bus
);
    localparam int IW = idx_w(NUM_REQ);

    state_t                r_state, w_state_nxt;
    logic [IW-1:0]         r_ptr, w_ptr_nxt, r_g, w_g_nxt, r_err_id, w_err_id_nxt, w_pick_idx;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt, r_ss_n, w_ss_n_nxt, r_end, w_end_nxt, w_pick_oh;
    logic [SPI_BYTE_W-1:0] r_rdata, w_rdata_nxt, r_sdata, w_sdata_nxt, w_sel_byte;
    logic                  r_begin, w_begin_nxt, r_terr, w_terr_nxt;
    logic                  w_pick_any, w_req_g, w_begin_g, w_time_up, w_gap_up;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_onehot(w_pick_oh),
        .o_index (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_req_g   = bus.req[r_g];
    assign w_begin_g = bus.begin_in[r_g];
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_time_up = w_cnt_inc >= TIMEOUT;
    assign w_gap_up  = w_cnt_inc >= CNT_W'(SS_GAP);

    assign bus.gnt                = r_gnt;
    assign bus.ss_n               = r_ss_n;
    assign bus.end_out            = r_end;
    assign bus.recieved_data_out  = r_rdata;
    assign bus.begin_transmission = r_begin;
    assign bus.send_data          = r_sdata;
    assign bus.timeout_err        = r_terr;
    assign bus.err_id             = r_err_id;

    // byte offered by the currently granted requester; others are ignored
    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_sel_byte = (r_g == IW'(i)) ? bus.send_data_in[i*SPI_BYTE_W +: SPI_BYTE_W] : w_sel_byte;
    end

    // state and registered outputs; a low rst abandons any byte in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_g      <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_ss_n   <= '1;
            r_end    <= '0;
            r_rdata  <= '0;
            r_sdata  <= '0;
            r_begin  <= 1'b0;
            r_terr   <= 1'b0;
            r_err_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_g      <= w_g_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ss_n   <= w_ss_n_nxt;
            r_end    <= w_end_nxt;
            r_rdata  <= w_rdata_nxt;
            r_sdata  <= w_sdata_nxt;
            r_begin  <= w_begin_nxt;
            r_terr   <= w_terr_nxt;
            r_err_id <= w_err_id_nxt;
        end
    end

    // next state: a dropped req beats begin_in, a finished byte beats the timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_pick_any ? ST_GRANT : ST_IDLE;
            ST_GRANT: w_state_nxt = !w_req_g ? ST_GAP : (w_begin_g ? ST_BUSY : ST_GRANT);
            ST_BUSY:  w_state_nxt = bus.end_transmission ? ST_DONE : (w_time_up ? ST_GAP : ST_BUSY);
            ST_DONE:  w_state_nxt = ST_GRANT;
            ST_GAP:   w_state_nxt = w_gap_up ? ST_IDLE : ST_GAP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // next values of grant, slave selects, byte handshake, error report and the shared counter
    always_comb begin
        w_gnt_nxt    = r_gnt;
        w_ss_n_nxt   = r_ss_n;
        w_g_nxt      = r_g;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_sdata_nxt  = r_sdata;
        w_begin_nxt  = r_begin;
        w_rdata_nxt  = r_rdata;
        w_end_nxt    = '0;
        w_terr_nxt   = 1'b0;
        w_err_id_nxt = r_err_id;
        case (r_state)
            ST_IDLE: if (w_pick_any) begin
                w_gnt_nxt  = w_pick_oh;
                w_ss_n_nxt = ~w_pick_oh;
                w_g_nxt    = w_pick_idx;
                w_ptr_nxt  = (w_pick_idx == IW'(NUM_REQ - 1)) ? '0 : w_pick_idx + IW'(1);
            end
            ST_GRANT: if (!w_req_g) begin
                w_gnt_nxt  = '0;
                w_ss_n_nxt = '1;
                w_cnt_nxt  = '0;
            end else if (w_begin_g) begin
                w_sdata_nxt = w_sel_byte;
                w_begin_nxt = 1'b1;
                w_cnt_nxt   = '0;
            end
            ST_BUSY: if (bus.end_transmission) begin
                w_rdata_nxt = bus.recieved_data;
                w_end_nxt   = r_gnt;
                w_begin_nxt = 1'b0;
            end else if (w_time_up) begin
                w_terr_nxt   = 1'b1;
                w_err_id_nxt = r_g;
                w_begin_nxt  = 1'b0;
                w_gnt_nxt    = '0;
                w_ss_n_nxt   = '1;
                w_cnt_nxt    = '0;
            end else begin
                w_cnt_nxt = w_cnt_inc;
            end
            ST_GAP: w_cnt_nxt = w_cnt_inc;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed and randomized checks of spi_bus_arbiter against a transaction-level model
module tb_spi_bus_arbiter;
    localparam int NR    = 2;
    localparam int TO_I  = 16;
    localparam int GAP_I = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rr_ptr = 0;

    spi_bus_arbiter_if #(.NUM_REQ(NR)) bus ();

    spi_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT(24'(TO_I)), .SS_GAP(12'(GAP_I))) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_gnt"}, 32'(bus.gnt), 0);
        chk({t, "_ss_n"}, 32'(bus.ss_n), 3);
        chk({t, "_end_out"}, 32'(bus.end_out), 0);
        chk({t, "_begin"}, 32'(bus.begin_transmission), 0);
        chk({t, "_send_data"}, 32'(bus.send_data), 0);
        chk({t, "_rx_out"}, 32'(bus.recieved_data_out), 0);
        chk({t, "_terr"}, 32'(bus.timeout_err), 0);
        chk({t, "_err_id"}, 32'(bus.err_id), 0);
    endtask

    // model: first requester at or after the pointer, then the pointer moves past it
    task automatic wait_grant(input logic [NR-1:0] mask, input int exp_cyc, output int g);
        int k;
        logic [NR-1:0] oh, nss;
        g = -1;
        for (int j = 0; j < NR; j++) begin
            int c = (rr_ptr + j) % NR;
            if (g < 0 && ((int'(mask) >> c) & 1) == 1) g = c;
        end
        rr_ptr = (g + 1) % NR;
        oh = NR'(1) << g;
        nss = ~oh;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.gnt == '0 && k < 64);
        chk("grant_arrived", 32'(k < 64), 1);
        chk("gnt", 32'(bus.gnt), 32'(oh));
        chk("ss_n_grant", 32'(bus.ss_n), 32'(nss));
        if (exp_cyc > 0) chk("grant_latency", k, exp_cyc);
    endtask

    task automatic chk_gap();
        chk("gap_gnt", 32'(bus.gnt), 0);
        chk("gap_ss_n", 32'(bus.ss_n), 3);
    endtask

    // one byte on requester i; the SPI master answers after lat busy cycles, never if lat exceeds the timeout
    task automatic do_byte(input int i, input logic [7:0] tx, input int lat, input logic [7:0] rx);
        logic [NR-1:0] oh, nss;
        int lim;
        oh = NR'(1) << i;
        nss = ~oh;
        lim = (lat > TO_I) ? TO_I : lat;
        bus.send_data_in = (16'($urandom) & ~(16'hFF << (8 * i))) | (16'(tx) << (8 * i));
        bus.begin_in = oh | NR'($urandom);
        @(negedge clk);
        chk("send_data", 32'(bus.send_data), 32'(tx));
        for (int c = 1; c <= lim; c++) begin
            chk("busy_begin", 32'(bus.begin_transmission), 1);
            chk("busy_no_end", 32'(bus.end_out), 0);
            bus.end_transmission = (c == lat);
            bus.recieved_data = (c == lat) ? rx : 8'($urandom);
            @(negedge clk);
        end
        bus.end_transmission = 1'b0;
        bus.recieved_data = 8'($urandom);
        bus.begin_in = '0;
        if (lat <= TO_I) begin
            chk("end_out", 32'(bus.end_out), 32'(oh));
            chk("rx_data", 32'(bus.recieved_data_out), 32'(rx));
            chk("begin_drop", 32'(bus.begin_transmission), 0);
            chk("no_terr", 32'(bus.timeout_err), 0);
            chk("ss_n_held", 32'(bus.ss_n), 32'(nss));
            @(negedge clk);
            chk("end_once", 32'(bus.end_out), 0);
            chk("rx_hold", 32'(bus.recieved_data_out), 32'(rx));
            chk("no_terr_after", 32'(bus.timeout_err), 0);
        end else begin
            chk("terr", 32'(bus.timeout_err), 1);
            chk("err_id", 32'(bus.err_id), 32'(i));
            chk("abort_ss_n", 32'(bus.ss_n), 3);
            chk("abort_gnt", 32'(bus.gnt), 0);
            chk("abort_begin", 32'(bus.begin_transmission), 0);
            chk("abort_no_end", 32'(bus.end_out), 0);
            @(negedge clk);
            chk("terr_once", 32'(bus.timeout_err), 0);
        end
    endtask

    initial begin
        int g, nb, lat;
        logic [NR-1:0] m;
        bus.req = '0;
        bus.begin_in = '0;
        bus.send_data_in = '0;
        bus.end_transmission = 1'b0;
        bus.recieved_data = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");

        // single request
        rst = 1'b1;
        bus.req = 2'b01;
        wait_grant(2'b01, 1, g);
        do_byte(g, 8'hA6, 8, 8'h5A);
        bus.req = 2'b00;
        @(negedge clk);
        chk_gap();

        // contention straight out of reset
        rst = 1'b0;
        bus.req = 2'b11;
        @(negedge clk);
        rr_ptr = 0;
        rst = 1'b1;
        wait_grant(2'b11, 1, g);
        do_byte(g, 8'h3C, 5, 8'hC3);
        bus.req = 2'b10;
        wait_grant(2'b10, GAP_I + 2, g);
        do_byte(g, 8'h81, 3, 8'h18);
        bus.req = 2'b01;
        @(negedge clk);
        chk_gap();
        bus.req = 2'b11;
        wait_grant(2'b11, GAP_I + 1, g);

        // burst of seven bytes under one grant, then fairness with both requesting
        do_byte(g, 8'hE8, 4, 8'($urandom));
        for (int b = 0; b < 6; b++) do_byte(g, 8'h00, $urandom_range(1, 6), 8'($urandom));
        bus.req = bus.req & ~(NR'(1) << g);
        @(negedge clk);
        chk_gap();
        bus.req = 2'b11;
        wait_grant(2'b11, GAP_I + 1, g);

        // timeout, regrant after the gap, then end_transmission on the timeout cycle
        do_byte(g, 8'h77, TO_I + 4, 8'h00);
        wait_grant(2'b11, GAP_I, g);
        do_byte(g, 8'h99, TO_I, 8'h66);
        bus.req = bus.req & ~(NR'(1) << g);
        @(negedge clk);
        chk_gap();
        bus.req = 2'b00;

        // reset in the middle of a byte
        bus.req = 2'b01;
        wait_grant(2'b01, -1, g);
        bus.send_data_in = 16'h0042;
        bus.begin_in = 2'b01;
        @(negedge clk);
        chk("mid_begin", 32'(bus.begin_transmission), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.begin_in = '0;
        bus.req = 2'b10;
        bus.end_transmission = 1'b1;
        @(negedge clk);
        chk_reset("rst_mid");
        bus.end_transmission = 1'b0;
        rr_ptr = 0;
        rst = 1'b1;
        wait_grant(2'b10, 1, g);
        chk("post_rst_no_end", 32'(bus.end_out), 0);
        bus.req = 2'b00;
        @(negedge clk);
        chk_gap();

        // randomized transactions against the model
        for (int r = 0; r < 12; r++) begin
            m = NR'($urandom_range(1, 3));
            bus.req = m;
            wait_grant(m, -1, g);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                lat = $urandom_range(1, TO_I + 4);
                do_byte(g, 8'($urandom), lat, 8'($urandom));
                if (lat > TO_I) break;
            end
            bus.req = bus.req & ~(NR'(1) << g);
            @(negedge clk);
            chk_gap();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one byte-level SPI master between NUM_REQ sensor FSMs (e.g. gyro FSM, accelerometer FSM).
- Grants the bus to one requester per transaction, round-robin, and drives that requester's active-low slave select.
- Routes the requester's byte handshake to the master and returns the end pulse and received byte.
- Sits between the sensor FSMs and the shared SPI master in the sensor subsystem.

Parameters:
NUM_REQ, 2, number of requesters and slave selects
TIMEOUT, 24'hFFFFFF, max cycles a byte may stay in flight before abort
SS_GAP, 12'hFFF, cycles all slave selects stay high between grants

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
req  input  NUM_REQ  per-requester transaction request, held high for whole transaction
begin_in  input  NUM_REQ  per-requester byte start, level
send_data_in  input  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i]
gnt  output  NUM_REQ  one-hot grant
end_out  output  NUM_REQ  one-cycle byte-done pulse, only to the granted requester
recieved_data_out  output  8  last received byte, shared by all requesters
begin_transmission  output  1  to SPI master
send_data  output  8  to SPI master
end_transmission  input  1  from SPI master
recieved_data  input  8  from SPI master
ss_n  output  NUM_REQ  active-low slave selects
timeout_err  output  1  one-cycle pulse on byte abort
err_id  output  $clog2(NUM_REQ)  index of requester whose byte timed out; valid with timeout_err

Behaviour:
- Reset (rst==0 at posedge clk):
  - State goes to IDLE.
  - gnt=0, end_out=0, ss_n=all 1, begin_transmission=0, send_data=0, recieved_data_out=0, timeout_err=0, err_id=0.
  - Round-robin pointer is set so requester 0 has highest priority.
  - Counters clear.
  - Reset during BUSY abandons the byte; no end_out is issued.
- States: IDLE, GRANT, BUSY, DONE, GAP.
- IDLE:
  - If any req bit is high, pick the first set bit scanning from ptr upward with wrap; call it g.
  - Register gnt=onehot(g), drop ss_n[g] low, set ptr=g+1 mod NUM_REQ, go to GRANT.
  - gnt and ss_n are visible 1 cycle after req is sampled.
- GRANT:
  - If req[g]==0: go to GAP.
  - Else if begin_in[g]==1: latch send_data=send_data_in[g], set begin_transmission=1, clear the timeout counter, go to BUSY.
  - The req check takes precedence over begin_in.
  - begin_in and send_data_in of non-granted requesters are ignored.
- BUSY:
  - begin_transmission is held at 1.
  - On end_transmission: recieved_data_out<=recieved_data, end_out[g]<=1 for one cycle, begin_transmission<=0, go to DONE.
  - Else if the counter reaches TIMEOUT: timeout_err=1 for one cycle, err_id=g, begin_transmission=0, go to GAP.
  - A req[g] drop during BUSY has no effect until the byte ends.
- DONE:
  - Lasts exactly one cycle; begin_in is ignored in it.
  - Requesters must drop begin_in in the cycle end_out is high, or the byte is relaunched.
  - Then go to GRANT.
- GAP:
  - gnt=0, ss_n=all 1, counter counts to SS_GAP, then go to IDLE.
  - New requests are not granted during GAP.
- Fairness: a requester cannot be regranted while another requester has req high at the GAP→IDLE transition.
- Counters saturate only at their terminal value; no wrap-around behaviour is reachable.
- Simultaneous end_transmission and TIMEOUT in the same cycle: end_transmission wins and no error is raised.
- Invariants:
  - At most one gnt bit is set.
  - ss_n[i]==0 implies gnt[i]==1.
  - begin_transmission==1 only in BUSY.

Decomposition:
- Shared package sensor_bus_pkg: the state enum typedef, NUM_REQ default, SS_GAP and TIMEOUT defaults, and the SPI byte-handshake constants shared with the sensor FSMs.
- One natural sub-module, rr_picker: combinational round-robin priority encoder.
  - Inputs: req and ptr.
  - Outputs: onehot, index, any.

Test Plan:
- Single request: req=01, begin_in[0] pulsed with byte A6; master ends after 8 cycles returning 5A -> gnt=01, ss_n=10, send_data=A6, begin_transmission high 8 cycles, end_out=01 for 1 cycle, recieved_data_out=5A.
- Contention: req=11 from reset -> requester 0 granted first; after its req drops and SS_GAP+1 cycles, requester 1 granted; next contention grants 0 again.
- Burst: granted requester sends E8 then six 00 bytes before dropping req -> exactly 7 end_out pulses, ss_n held low throughout, then GAP.
- Timeout: TIMEOUT=16 and end_transmission never asserted -> timeout_err pulse at cycle 16 of BUSY, err_id=granted index, ss_n all high, bus regranted after GAP.
- Reset mid-byte: rst low during BUSY -> next cycle all outputs at reset values, no end_out; after release, req=10 is granted to requester 1.
- Tie case: end_transmission on the same cycle TIMEOUT is reached -> end_out pulses and timeout_err stays 0.
